alarm_set_ctrl: RTL and testbench
=================================

// Module: alarm_set_ctrl
// PURPOSE
//  Button-driven user-interface controller for the alarm clock core.
//  - Turns three debounced single-cycle button pulses (mode/inc/set) into the clock core's configuration strobes.
//  - Outputs: BCD time/alarm preset digits, LD_time/LD_alarm, AL_ON, STOP_al.
//  - Sits between the front-panel debouncers and the clock core. Sole driver of the core's H_in*/M_in*/LD_*/AL_ON/STOP_al inputs.
// PARAMETERS
//  TIMEOUT_CYC  100  idle cycles in any edit state before abort to IDLE (100 = 10 s at the 10 Hz core clock)
//  CW           7    width of timeout counter; must satisfy 2**CW > TIMEOUT_CYC
// PORTS
//  clk        in   1  core clock (same clock as the clock core)
//  reset      in   1  synchronous, active-high reset
//  btn_mode   in   1  one-cycle pulse: enter/cycle edit mode
//  btn_inc    in   1  one-cycle pulse: increment field / toggle alarm enable
//  btn_set    in   1  one-cycle pulse: advance field / commit / stop alarm
//  Alarm      in   1  alarm output of clock core
//  H_cur1     in   2  current time, hours tens (BCD)
//  H_cur0     in   4  current time, hours units (BCD)
//  M_cur1     in   3  current time, minutes tens (BCD)
//  M_cur0     in   4  current time, minutes units (BCD)
//  H_in1      out  2  edit register, hours tens
//  H_in0      out  4  edit register, hours units
//  M_in1      out  3  edit register, minutes tens
//  M_in0      out  4  edit register, minutes units
//  LD_time    out  1  one-cycle load strobe to core time registers
//  LD_alarm   out  1  one-cycle load strobe to core alarm registers
//  AL_ON      out  1  alarm enable (level)
//  STOP_al    out  1  one-cycle alarm-stop pulse
//  edit_mode  out  2  0 = none, 1 = time, 2 = alarm (drives panel blink)
//  edit_field out  1  0 = hours, 1 = minutes
// BEHAVIOUR
//  Reset
//  - All outputs 0; state IDLE.
//  - Alarm shadow register = 00:00; timeout counter = 0.
//  Inputs
//  - Registered FSM. All outputs are registered and change 1 cycle after the causing button.
//  - Button priority per cycle: set > mode > inc. Lower-priority pulses in the same cycle are dropped.
//  States: IDLE, T_HOUR, T_MIN, A_HOUR, A_MIN.
//  IDLE
//  - mode -> T_HOUR; edit reg loaded from H_cur*/M_cur*.
//  - inc -> toggle AL_ON.
//  - set -> STOP_al=1 for 1 cycle if Alarm=1; otherwise no effect.
//  T_HOUR / A_HOUR
//  - inc -> hours +1 BCD, 23 -> 00.
//  - set -> go to *_MIN.
//  T_MIN / A_MIN
//  - inc -> minutes +1 BCD, 59 -> 00; hours unchanged.
//  - set -> LD_time (T_MIN) or LD_alarm (A_MIN) high for exactly 1 cycle, then IDLE.
//  - A_MIN commit also copies the edit reg into the alarm shadow.
//  - Edit reg holds its value after commit, so digits are stable while LD_* is high.
//  Mode press in an edit state
//  - From T_*: -> A_HOUR; edit reg loaded from alarm shadow.
//  - From A_*: -> IDLE, edit discarded, no strobe.
//  Timeout
//  - Counter clears on any button pulse and on state entry.
//  - At TIMEOUT_CYC consecutive no-button cycles in an edit state: -> IDLE, no strobe.
//  - Counter is held at 0 in IDLE.
//  Independence from edit state
//  - AL_ON and STOP_al are untouched by edit-state activity.
//  - Alarm asserting during edit is not auto-stopped.
//  edit_mode / edit_field decode directly from the registered state.
//  Invariant: LD_time and LD_alarm are never high together, and never high 2 cycles in a row.
//  Reset mid-edit: abort to IDLE, no strobe, AL_ON cleared.
// STRUCTURE
//  Shared package clock_pkg
//  - FSM state encoding (3-bit typedef).
//  - Constants HOUR_MAX=23, MIN_MAX=59, EDIT_NONE/TIME/ALARM.
//  - Shared with the clock core and the display driver.
//  One sub-module: bcd2_inc
//  - Parameterised 2-digit BCD incrementer with wrap at MAX.
//  - Instanced twice: hours and minutes.
//  FSM, timeout counter and alarm shadow stay in this module.
// TESTING
//  - Reset, then 3 mode pulses 2 cycles apart
//    -> edit_mode 1, 2, 0; no LD_* pulse; edit reg = cur time, then 00:00.
//  - cur=11:26; mode, inc x13, set, inc x40, set
//    -> LD_time 1 cycle, digits 00:06 (hours 11+13 wraps to 00, minutes 26+40 wraps to 06).
//  - IDLE inc -> AL_ON=1; second inc -> AL_ON=0.
//  - Alarm=1, set pulse -> STOP_al exactly 1 cycle; with Alarm=0 -> no pulse.
//  - Enter A_HOUR, inc x2, wait TIMEOUT_CYC cycles
//    -> IDLE, no LD_alarm, shadow still 00:00.
//  - Same-cycle set+inc in T_HOUR -> T_MIN, hours unchanged.
//  - reset in A_MIN -> all outputs 0 next cycle.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared alarm-clock types: FSM state encoding, BCD time bundle, limits.
// Used by the clock core, the panel display driver and alarm_set_ctrl.
package clock_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_T_HOUR = 3'd1,
      S_T_MIN  = 3'd2,
      S_A_HOUR = 3'd3,
      S_A_MIN  = 3'd4
   } state_e;

   localparam int HOUR_MAX = 23;
   localparam int MIN_MAX  = 59;

   localparam logic [1:0] EDIT_NONE  = 2'd0;
   localparam logic [1:0] EDIT_TIME  = 2'd1;
   localparam logic [1:0] EDIT_ALARM = 2'd2;

   typedef struct packed {
      logic [1:0] h1;
      logic [3:0] h0;
      logic [2:0] m1;
      logic [3:0] m0;
   } hhmm_t;

endpackage

// File: rtl/bcd2_inc.sv
// Two-digit BCD incrementer; MAX wraps back to 00.
// Tens digit width is a parameter so hours (2b) and minutes (3b) share it.
module bcd2_inc #(
   parameter int MAX = 59,
   parameter int W1  = 3
) (
   input  logic [W1-1:0] tens_i,
   input  logic [3:0]    ones_i,
   output logic [W1-1:0] tens_o,
   output logic [3:0]    ones_o
);

   localparam logic [W1-1:0] MAX1 = W1'(MAX / 10);
   localparam logic [3:0]    MAX0 = 4'(MAX % 10);

   always_comb begin
      tens_o = tens_i;
      ones_o = ones_i + 4'd1;
      if (tens_i == MAX1 && ones_i == MAX0) begin
         tens_o = '0;
         ones_o = '0;
      end else if (ones_i == 4'd9) begin
         tens_o = tens_i + W1'(1);
         ones_o = '0;
      end
   end

endmodule

// File: rtl/alarm_set_ctrl.sv
// Front-panel edit controller: turns mode/inc/set pulses into the
// clock core's preset digits, load strobes, alarm enable and stop.
module alarm_set_ctrl
   import clock_pkg::*;
#(
   parameter int TIMEOUT_CYC = 100,
   parameter int CW          = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_set,
   input  logic       Alarm,
   input  logic [1:0] H_cur1,
   input  logic [3:0] H_cur0,
   input  logic [2:0] M_cur1,
   input  logic [3:0] M_cur0,
   output logic [1:0] H_in1,
   output logic [3:0] H_in0,
   output logic [2:0] M_in1,
   output logic [3:0] M_in0,
   output logic       LD_time,
   output logic       LD_alarm,
   output logic       AL_ON,
   output logic       STOP_al,
   output logic [1:0] edit_mode,
   output logic       edit_field
);

   state_e        state_q;
   hhmm_t         edit_q;
   hhmm_t         shadow_q;
   hhmm_t         cur;
   logic [CW-1:0] cnt_q;
   logic          ld_time_q;
   logic          ld_alarm_q;
   logic          al_on_q;
   logic          stop_q;

   logic [1:0]    h1_nx;
   logic [3:0]    h0_nx;
   logic [2:0]    m1_nx;
   logic [3:0]    m0_nx;
   logic          any_btn;
   logic          in_edit;
   logic          tmo;

   assign cur     = '{h1: H_cur1, h0: H_cur0, m1: M_cur1, m0: M_cur0};
   assign any_btn = btn_mode | btn_inc | btn_set;
   assign in_edit = (state_q != S_IDLE);
   assign tmo     = in_edit && !any_btn &&
                    (cnt_q == CW'(TIMEOUT_CYC - 1));

   bcd2_inc #(.MAX(HOUR_MAX), .W1(2)) u_hour_inc (
      .tens_i (edit_q.h1),
      .ones_i (edit_q.h0),
      .tens_o (h1_nx),
      .ones_o (h0_nx)
   );

   bcd2_inc #(.MAX(MIN_MAX), .W1(3)) u_min_inc (
      .tens_i (edit_q.m1),
      .ones_i (edit_q.m0),
      .tens_o (m1_nx),
      .ones_o (m0_nx)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         edit_q     <= '0;
         shadow_q   <= '0;
         cnt_q      <= '0;
         ld_time_q  <= 1'b0;
         ld_alarm_q <= 1'b0;
         al_on_q    <= 1'b0;
         stop_q     <= 1'b0;
      end else begin
         ld_time_q  <= 1'b0;
         ld_alarm_q <= 1'b0;
         stop_q     <= 1'b0;
         // counts consecutive idle cycles while editing
         if (!in_edit || any_btn || tmo) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + CW'(1);
         end
         unique case (state_q)
            S_IDLE: begin
               if (btn_set) begin
                  stop_q <= Alarm;
               end else if (btn_mode) begin
                  state_q <= S_T_HOUR;
                  edit_q  <= cur;
               end else if (btn_inc) begin
                  al_on_q <= ~al_on_q;
               end
            end
            S_T_HOUR, S_A_HOUR: begin
               if (btn_set) begin
                  state_q <= (state_q == S_T_HOUR) ? S_T_MIN : S_A_MIN;
               end else if (btn_mode) begin
                  if (state_q == S_T_HOUR) begin
                     state_q <= S_A_HOUR;
                     edit_q  <= shadow_q;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (btn_inc) begin
                  edit_q.h1 <= h1_nx;
                  edit_q.h0 <= h0_nx;
               end else if (tmo) begin
                  state_q <= S_IDLE;
               end
            end
            S_T_MIN, S_A_MIN: begin
               if (btn_set) begin
                  state_q <= S_IDLE;
                  if (state_q == S_T_MIN) begin
                     ld_time_q <= 1'b1;
                  end else begin
                     ld_alarm_q <= 1'b1;
                     shadow_q   <= edit_q;
                  end
               end else if (btn_mode) begin
                  if (state_q == S_T_MIN) begin
                     state_q <= S_A_HOUR;
                     edit_q  <= shadow_q;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (btn_inc) begin
                  edit_q.m1 <= m1_nx;
                  edit_q.m0 <= m0_nx;
               end else if (tmo) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      edit_mode  = EDIT_NONE;
      edit_field = 1'b0;
      unique case (state_q)
         S_T_HOUR: edit_mode = EDIT_TIME;
         S_T_MIN: begin
            edit_mode  = EDIT_TIME;
            edit_field = 1'b1;
         end
         S_A_HOUR: edit_mode = EDIT_ALARM;
         S_A_MIN: begin
            edit_mode  = EDIT_ALARM;
            edit_field = 1'b1;
         end
         default: edit_mode = EDIT_NONE;
      endcase
   end

   assign H_in1    = edit_q.h1;
   assign H_in0    = edit_q.h0;
   assign M_in1    = edit_q.m1;
   assign M_in0    = edit_q.m0;
   assign LD_time  = ld_time_q;
   assign LD_alarm = ld_alarm_q;
   assign AL_ON    = al_on_q;
   assign STOP_al  = stop_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Scoreboard bench for alarm_set_ctrl: directed button vectors queue
// hand-computed output snapshots; a monitor pops them cycle by cycle.
module tb_alarm_set_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_inc = 1'b0;
   logic       btn_set = 1'b0;
   logic       Alarm = 1'b0;
   logic [1:0] H_cur1 = '0;
   logic [3:0] H_cur0 = '0;
   logic [2:0] M_cur1 = '0;
   logic [3:0] M_cur0 = '0;
   logic [1:0] H_in1;
   logic [3:0] H_in0;
   logic [2:0] M_in1;
   logic [3:0] M_in0;
   logic       LD_time;
   logic       LD_alarm;
   logic       AL_ON;
   logic       STOP_al;
   logic [1:0] edit_mode;
   logic       edit_field;

   alarm_set_ctrl #(.TIMEOUT_CYC(100), .CW(7)) dut (
      .clk        (clk),
      .reset      (reset),
      .btn_mode   (btn_mode),
      .btn_inc    (btn_inc),
      .btn_set    (btn_set),
      .Alarm      (Alarm),
      .H_cur1     (H_cur1),
      .H_cur0     (H_cur0),
      .M_cur1     (M_cur1),
      .M_cur0     (M_cur0),
      .H_in1      (H_in1),
      .H_in0      (H_in0),
      .M_in1      (M_in1),
      .M_in0      (M_in0),
      .LD_time    (LD_time),
      .LD_alarm   (LD_alarm),
      .AL_ON      (AL_ON),
      .STOP_al    (STOP_al),
      .edit_mode  (edit_mode),
      .edit_field (edit_field)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      string       nm;
      int          due;
      logic [19:0] exp;
      bit          dig;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   logic [12:0] e_dig = '0;
   bit          e_dig_v = 1'b1;
   logic        e_ldt = 1'b0;
   logic        e_lda = 1'b0;
   logic        e_al = 1'b0;
   logic        e_stop = 1'b0;
   logic [1:0]  e_mode = '0;
   logic        e_fld = 1'b0;

   function automatic logic [12:0] bcd(input int h, input int m);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
   endfunction

   function automatic void push(input string nm, input int due,
                                input logic ldt, input logic lda,
                                input logic stp);
      exp_t e;
      e.nm  = nm;
      e.due = due;
      e.exp = {e_dig, ldt, lda, e_al, stp, e_mode, e_fld};
      e.dig = e_dig_v;
      q.push_back(e);
   endfunction

   // monitor: compares every queued snapshot in the cycle it is due
   logic prev_ld = 1'b0;
   always @(posedge clk) begin
      logic [19:0] got;
      logic [19:0] msk;
      exp_t        e;
      #1;
      got = {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm,
             AL_ON, STOP_al, edit_mode, edit_field};
      while (q.size() > 0 && q[0].due <= cyc) begin
         e   = q.pop_front();
         msk = e.dig ? 20'hfffff : 20'h0007f;
         checks++;
         if (e.due != cyc || ((got ^ e.exp) & msk) != '0) begin
            errors++;
            $display("FAIL %s cyc=%0d due=%0d got=%h exp=%h mask=%h",
                     e.nm, cyc, e.due, got, e.exp, msk);
         end
      end
      if (LD_time === 1'b1 || LD_alarm === 1'b1) begin
         checks++;
         if ((LD_time && LD_alarm) || prev_ld) begin
            errors++;
            $display("FAIL ld_invariant cyc=%0d got LD_time=%b LD_alarm=%b prev=%b exp single isolated strobe",
                     cyc, LD_time, LD_alarm, prev_ld);
         end
      end
      prev_ld = (LD_time === 1'b1) || (LD_alarm === 1'b1);
   end

   task automatic setcur(input int h, input int m);
      {H_cur1, H_cur0, M_cur1, M_cur0} = bcd(h, m);
   endtask

   // one stimulus cycle plus one quiet cycle; strobes must last one cycle
   task automatic go(input bit m, input bit i, input bit s, input bit r,
                     input string nm);
      @(negedge clk);
      btn_mode = m;
      btn_inc  = i;
      btn_set  = s;
      reset    = r;
      push(nm, cyc + 1, e_ldt, e_lda, e_stop);
      push({nm, "_hold"}, cyc + 2, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      btn_set  = 1'b0;
      reset    = 1'b0;
      e_ldt  = 1'b0;
      e_lda  = 1'b0;
      e_stop = 1'b0;
   endtask

   task automatic idle(input int n, input string nm);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         push(nm, cyc + 1, 1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      go(0, 0, 0, 1, "reset");

      // three mode presses: time edit, alarm edit, idle
      setcur(12, 34);
      e_mode = 2'd1; e_dig = bcd(12, 34);
      go(1, 0, 0, 0, "mode1");
      e_mode = 2'd2; e_dig = bcd(0, 0);
      go(1, 0, 0, 0, "mode2");
      e_mode = 2'd0; e_dig_v = 1'b0;
      go(1, 0, 0, 0, "mode3");
      e_dig_v = 1'b1;

      // time set with hour and minute wrap
      setcur(11, 26);
      e_mode = 2'd1; e_dig = bcd(11, 26);
      go(1, 0, 0, 0, "t_enter");
      for (int i = 1; i <= 13; i++) begin
         e_dig = bcd((11 + i) % 24, 26);
         go(0, 1, 0, 0, $sformatf("hinc%0d", i));
      end
      e_fld = 1'b1;
      go(0, 0, 1, 0, "to_min");
      for (int i = 1; i <= 40; i++) begin
         e_dig = bcd(0, (26 + i) % 60);
         go(0, 1, 0, 0, $sformatf("minc%0d", i));
      end
      e_mode = 2'd0; e_fld = 1'b0; e_ldt = 1'b1;
      go(0, 0, 1, 0, "ld_time");

      // alarm enable toggle
      e_al = 1'b1;
      go(0, 1, 0, 0, "al_on1");
      e_al = 1'b0;
      go(0, 1, 0, 0, "al_off");
      e_al = 1'b1;
      go(0, 1, 0, 0, "al_on2");

      // alarm stop pulse
      Alarm = 1'b1; e_stop = 1'b1;
      go(0, 0, 1, 0, "stop1");
      Alarm = 1'b0;
      go(0, 0, 1, 0, "stop0");

      // alarm edit timeout; alarm ringing is not auto-stopped
      setcur(12, 34);
      e_mode = 2'd1; e_dig = bcd(12, 34);
      go(1, 0, 0, 0, "to_t");
      e_mode = 2'd2; e_dig = bcd(0, 0);
      go(1, 0, 0, 0, "to_a");
      Alarm = 1'b1;
      e_dig = bcd(1, 0);
      go(0, 1, 0, 0, "to_inc1");
      e_dig = bcd(2, 0);
      go(0, 1, 0, 0, "to_inc2");
      idle(98, "to_wait");
      e_mode = 2'd0; e_dig_v = 1'b0;
      idle(3, "to_idle");
      Alarm = 1'b0; e_dig_v = 1'b1;
      e_mode = 2'd1; e_dig = bcd(12, 34);
      go(1, 0, 0, 0, "sh_t");
      e_mode = 2'd2; e_dig = bcd(0, 0);
      go(1, 0, 0, 0, "shadow00");
      e_mode = 2'd0; e_dig_v = 1'b0;
      go(1, 0, 0, 0, "sh_exit");
      e_dig_v = 1'b1;

      // same-cycle priority and alarm commit
      e_mode = 2'd1; e_dig = bcd(12, 34);
      go(1, 0, 0, 0, "p_t");
      e_fld = 1'b1;
      go(0, 1, 1, 0, "set_over_inc");
      e_mode = 2'd2; e_fld = 1'b0; e_dig = bcd(0, 0);
      go(1, 1, 0, 0, "mode_over_inc");
      e_fld = 1'b1;
      go(1, 0, 1, 0, "set_over_mode");
      e_dig = bcd(0, 1);
      go(0, 1, 0, 0, "a_minc");
      e_mode = 2'd0; e_fld = 1'b0; e_lda = 1'b1;
      go(0, 0, 1, 0, "ld_alarm");
      e_mode = 2'd1; e_dig = bcd(12, 34);
      go(1, 0, 0, 0, "sh2_t");
      e_mode = 2'd2; e_dig = bcd(0, 1);
      go(1, 0, 0, 0, "shadow01");
      e_dig = bcd(1, 1);
      go(0, 1, 0, 0, "a_hinc");
      e_fld = 1'b1;
      go(0, 0, 1, 0, "a_min");

      // reset mid-edit
      e_mode = 2'd0; e_fld = 1'b0; e_dig = bcd(0, 0); e_al = 1'b0;
      go(0, 0, 0, 1, "reset_amin");
      idle(2, "post_reset");

      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got=%0d pending exp=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
